adder_sop_share_engine: RTL and testbench

ADDER_SOP_SHARE_ENGINE -- requirements
Module: adder_sop_share_engine

---
 rtl/adder_sop_pkg.sv | 29 ++
 rtl/sop_product_term.sv | 25 ++
 rtl/adder_sop_share_engine.sv | 146 ++++++++++++++
 tb/tb_adder_sop_share_engine.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sop_pkg.sv
// Shared types and helpers for the SOP approximate-adder engine: FSM states,
// per-input literal codes and configuration field widths.
package adder_sop_pkg;

    typedef enum logic [1:0] {
        ST_CFG   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Two bits per input, {pos,neg}; setting both makes the product unsatisfiable.
    localparam logic [1:0] LIT_DC   = 2'b00;
    localparam logic [1:0] LIT_POS  = 2'b10;
    localparam logic [1:0] LIT_NEG  = 2'b01;
    localparam logic [1:0] LIT_ZERO = 2'b11;

    function automatic int mask_width(input int n_in);
        return 2 * n_in;
    endfunction

    function automatic int cfg_width(input int n_in, input int n_out);
        return 2 * n_in + n_out;
    endfunction

    function automatic int idx_width(input int n_pit);
        return (n_pit > 1) ? $clog2(n_pit) : 1;
    endfunction

endpackage

// File: rtl/sop_product_term.sv
// One programmable product term: AND of the literals selected by its mask.
// An all-don't-care mask is treated as an empty (false) product.
module sop_product_term
    import adder_sop_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [2*N_IN-1:0] mask,
    input  logic [N_IN-1:0]   in_data,
    output logic              product
);

    always_comb begin
        product = |mask;
        for (int i = 0; i < N_IN; i++) begin
            case (mask[2*i +: 2])
                LIT_POS:  if (!in_data[i]) product = 1'b0;
                LIT_NEG:  if (in_data[i])  product = 1'b0;
                LIT_ZERO: product = 1'b0;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/adder_sop_share_engine.sv
// Programmable shared-product SOP approximate adder with a two-stage pipeline,
// exact reference sum, error flagging and error statistics.
module adder_sop_share_engine
    import adder_sop_pkg::*;
#(
    parameter int          N_IN  = 4,
    parameter int          N_OUT = 3,
    parameter int          N_PIT = 7,
    parameter int unsigned ET    = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_start,
    input  logic                                   cfg_we,
    input  logic [idx_width(N_PIT)-1:0]            cfg_idx,
    input  logic [cfg_width(N_IN, N_OUT)-1:0]      cfg_data,
    input  logic                                   cfg_commit,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N_IN-1:0]                        in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [N_OUT-1:0]                       out_data,
    output logic [N_OUT-1:0]                       out_exact,
    output logic                                   out_err_flag,
    output logic [15:0]                            err_cnt,
    output logic [N_OUT-1:0]                       max_err,
    output logic [1:0]                             state
);

    localparam int MW = mask_width(N_IN);
    localparam int CW = cfg_width(N_IN, N_OUT);
    localparam int HW = N_IN / 2;

    state_t state_q, state_d;

    logic [CW-1:0]    cfg_mem [N_PIT];
    logic [N_PIT-1:0] prod_c;
    logic [N_OUT-1:0] exact_c;

    logic             s1_valid;
    logic [N_PIT-1:0] s1_prod;
    logic [N_OUT-1:0] s1_exact;

    logic [N_OUT-1:0] approx_c;
    logic [N_OUT:0]   diff_c;
    logic [N_OUT:0]   err_abs_c;
    logic [N_OUT-1:0] s2_err_mag;

    logic advance;
    logic accept;
    logic handshake;
    logic commit_take;

    // Valid/ready: a beat moves when valid && ready at a rising edge; a stalled
    // output (valid && !ready) freezes both stages and holds every out_* stable.
    assign advance     = !(out_valid && !out_ready);
    assign in_ready    = (state_q == ST_RUN) && advance;
    assign accept      = in_valid && in_ready;
    assign handshake   = out_valid && out_ready;
    assign commit_take = (state_q == ST_CFG) && cfg_commit;
    assign state       = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_CFG;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CFG:   if (cfg_commit) state_d = ST_RUN;
            ST_RUN:   if (cfg_start)  state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_valid && !out_valid) state_d = ST_CFG;
            default:  state_d = ST_CFG;
        endcase
    end

    // A write coinciding with the commit still lands, since state is still CFG.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < N_PIT; p++) cfg_mem[p] <= '0;
        end else if (state_q == ST_CFG && cfg_we && int'(cfg_idx) < N_PIT) begin
            cfg_mem[cfg_idx] <= cfg_data;
        end
    end

    for (genvar p = 0; p < N_PIT; p++) begin : g_pit
        sop_product_term #(.N_IN(N_IN)) u_term (
            .mask    (cfg_mem[p][MW-1:0]),
            .in_data (in_data),
            .product (prod_c[p])
        );
    end

    assign exact_c = N_OUT'(in_data[HW-1:0]) + N_OUT'(in_data[N_IN-1:HW]);

    always_comb begin
        approx_c = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int p = 0; p < N_PIT; p++) begin
                approx_c[j] = approx_c[j] | (s1_prod[p] & cfg_mem[p][MW+j]);
            end
        end
    end

    assign diff_c    = {1'b0, approx_c} - {1'b0, s1_exact};
    assign err_abs_c = diff_c[N_OUT] ? -diff_c : diff_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_prod      <= '0;
            s1_exact     <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_exact    <= '0;
            out_err_flag <= 1'b0;
            s2_err_mag   <= '0;
        end else if (advance) begin
            s1_valid  <= accept;
            out_valid <= s1_valid;
            if (accept) begin
                s1_prod  <= prod_c;
                s1_exact <= exact_c;
            end
            if (s1_valid) begin
                out_data     <= approx_c;
                out_exact    <= s1_exact;
                out_err_flag <= 32'(err_abs_c) > ET;
                s2_err_mag   <= err_abs_c[N_OUT-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || commit_take) begin
            err_cnt <= '0;
            max_err <= '0;
        end else if (handshake) begin
            if (out_err_flag && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (s2_err_mag > max_err) max_err <= s2_err_mag;
        end
    end

endmodule

// File: tb/tb_adder_sop_share_engine.sv
// Directed bench for adder_sop_share_engine: hand-computed vectors, an expected
// queue of {out_data,out_exact,out_err_flag} checked on every delivered beat.
module tb_adder_sop_share_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [10:0] cfg_data;
    logic        cfg_commit;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_data;
    logic [2:0]  out_exact;
    logic        out_err_flag;
    logic [15:0] err_cnt;
    logic [2:0]  max_err;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;
    logic [6:0] exp_q[$];

    adder_sop_share_engine #(.N_IN(4), .N_OUT(3), .N_PIT(7), .ET(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_data     (cfg_data),
        .cfg_commit   (cfg_commit),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_exact    (out_exact),
        .out_err_flag (out_err_flag),
        .err_cnt      (err_cnt),
        .max_err      (max_err),
        .state        (state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every delivered beat must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out: observed=%0h expected=none",
                       {out_data, out_exact, out_err_flag});
            end
            if (exp_q.size() != 0) chk("out_beat", {out_data, out_exact, out_err_flag}, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic [6:0] e, input bit push);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_accept", 32'(n < 20), 32'd1);
        if (push) exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [10:0] d);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    initial begin
        int nacc;
        int cyc;
        logic [3:0] vecs [4];
        logic [2:0] snap_d;
        logic [2:0] snap_e;
        bit have_snap;

        rst_n = 1'b0; cfg_start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
        cfg_commit = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_state", state, 2'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_err_cnt", err_cnt, 16'd0);
        chk("rst_max_err", max_err, 3'd0);
        chk("rst_out_data", out_data, 3'd0);
        rst_n = 1'b1;
        tick();

        // All masks zero: approx 0, exact 3+3=6, flagged
        commit();
        chk("run_state", state, 2'd1);
        chk("run_in_ready", in_ready, 1'b1);
        send(4'b1111, 7'b000_110_1, 1'b1);
        chk("lat1_out_valid", out_valid, 1'b0);
        tick();
        chk("lat2_out_valid", out_valid, 1'b1);
        chk("lat2_out_data", out_data, 3'd0);
        chk("lat2_out_exact", out_exact, 3'd6);
        chk("lat2_err_flag", out_err_flag, 1'b1);
        wait_drain();
        chk("a_err_cnt", err_cnt, 16'd1);
        chk("a_max_err", max_err, 3'd6);

        // Empty pipeline: RUN -> DRAIN -> CFG
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("drain_state", state, 2'd2);
        tick();
        chk("back_to_cfg", state, 2'd0);

        // Product 0 = x0, drives out bit 0
        cfg_write(3'd0, 11'h102);
        commit();
        chk("commit_clr_cnt", err_cnt, 16'd0);
        chk("commit_clr_max", max_err, 3'd0);
        send(4'b0001, 7'b001_001_0, 1'b1);
        send(4'b0000, 7'b000_000_0, 1'b1);
        send(4'b0011, 7'b001_011_1, 1'b1);
        send(4'b1110, 7'b000_101_1, 1'b1);
        wait_drain();
        chk("b_err_cnt", err_cnt, 16'd2);
        chk("b_max_err", max_err, 3'd5);

        // Stall: out_ready low for 4 cycles with in_valid high
        vecs[0] = 4'b0101; vecs[1] = 4'b1000; vecs[2] = 4'b0011; vecs[3] = 4'b0110;
        out_ready = 1'b0;
        nacc = 0;
        have_snap = 1'b0;
        snap_d = '0;
        snap_e = '0;
        for (int c = 0; c < 4; c++) begin
            in_data  = vecs[nacc];
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                if (nacc == 0) exp_q.push_back(7'b001_010_0);
                else if (nacc == 1) exp_q.push_back(7'b000_010_1);
                else exp_q.push_back(7'b111_111_1);
                nacc++;
            end
            tick();
            if (out_valid) begin
                if (!have_snap) begin
                    snap_d = out_data;
                    snap_e = out_exact;
                    have_snap = 1'b1;
                end else begin
                    chk("stall_data_stable", out_data, snap_d);
                    chk("stall_exact_stable", out_exact, snap_e);
                end
            end
        end
        in_valid = 1'b0;
        chk("stall_accepts", nacc, 32'd2);
        out_ready = 1'b1;
        wait_drain();
        chk("c_err_cnt", err_cnt, 16'd3);

        // DRAIN with two beats in flight; write during DRAIN must be dropped
        out_ready = 1'b0;
        send(4'b0001, 7'b001_001_0, 1'b1);
        send(4'b0010, 7'b000_010_1, 1'b1);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("d_drain_state", state, 2'd2);
        cfg_write(3'd1, 11'h108);
        chk("d_drain_hold1", state, 2'd2);
        tick();
        chk("d_drain_hold2", state, 2'd2);
        out_ready = 1'b1;
        cyc = 0;
        while (state != 2'd0 && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("d_to_cfg", state, 2'd0);
        chk("d_all_delivered", 32'(exp_q.size()), 32'd0);
        commit();
        chk("d_commit_cnt", err_cnt, 16'd0);
        send(4'b0010, 7'b000_010_1, 1'b1);
        send(4'b0001, 7'b001_001_0, 1'b1);
        wait_drain();
        chk("d_err_cnt", err_cnt, 16'd1);
        chk("d_max_err", max_err, 3'd2);

        // Reset with both stages full
        out_ready = 1'b0;
        send(4'b1111, 7'b0, 1'b0);
        send(4'b0101, 7'b0, 1'b0);
        chk("e_full_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("e_rst_valid", out_valid, 1'b0);
        chk("e_rst_state", state, 2'd0);
        chk("e_rst_in_ready", in_ready, 1'b0);
        chk("e_rst_err_cnt", err_cnt, 16'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("e_no_ghost", out_valid, 1'b0);

        // Saturation: config cleared by reset, so every 1111 beat is flagged
        commit();
        in_data  = 4'b1111;
        in_valid = 1'b1;
        nacc = 0;
        cyc = 0;
        while (nacc < 65535 && cyc < 70000) begin
            if (in_ready) begin
                exp_q.push_back(7'b000_110_1);
                nacc++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("f_stream_count", nacc, 32'd65535);
        wait_drain();
        chk("f_err_cnt_full", err_cnt, 16'hFFFF);
        chk("f_max_err", max_err, 3'd6);
        send(4'b1111, 7'b000_110_1, 1'b1);
        wait_drain();
        chk("f_err_cnt_sat", err_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
